mdu_exec: RTL and testbench
===========================

Name: mdu_exec

Overview:
- Multiply/divide unit in the E stage, beside the ALU.
- Executes MULT, MULTU, DIV and DIVU with a fixed multi-cycle latency, plus MTHI and MTLO. Holds the architectural HI/LO registers.
- The hazard unit uses `occupied` to stall D-stage multiply/divide, MFHI/MFLO and MT* instructions.
- The E-stage mux forwards `hi`/`lo` into the M-stage pipeline register for MFHI/MFLO.

Parameters:
- MULT_CYCLES, 5, number of busy cycles for MULT/MULTU (range 1..15).
- DIV_CYCLES, 10, number of busy cycles for DIV/DIVU (range 1..15).

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  E-stage instruction is an MDU op; sampled on the rising edge.
- op  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved.
- a  in  32  rs operand (forwarded V1).
- b  in  32  rt operand (forwarded V2).
- busy  out  1  an operation is in flight.
- occupied  out  1  combinational: busy | (start & op in 1..4); drives the hazard unit.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.

Behaviour:
- Reset:
  - reset=0 immediately clears hi, lo, busy, the down-counter and the pending HI/LO registers, regardless of clk.
  - A reset asserted mid-operation aborts the operation; nothing commits.
- FSM has two states, IDLE and BUSY.
- IDLE, start=1, op 1..4:
  - At that edge, compute the 64-bit result into pending_hi/pending_lo.
  - Load the counter with MULT_CYCLES or DIV_CYCLES; busy becomes 1; go to BUSY.
- IDLE, start=1, op 5/6:
  - At that edge, hi<=a (MTHI) or lo<=a (MTLO); busy stays 0.
- IDLE, start=1, op 0 or 7: no effect.
- BUSY:
  - Counter decrements every edge.
  - On the edge where counter==1: hi<=pending_hi, lo<=pending_lo, busy<=0, go to IDLE.
  - The new values are therefore visible exactly N cycles after the start edge (N = MULT_CYCLES or DIV_CYCLES).
  - busy is high for exactly N cycles.
- start while busy=1 (any op) is ignored.
  - This is a hazard-unit protocol violation; the bench flags it with an assertion.
- hi/lo keep their old values during BUSY.
  - MFHI/MFLO must be stalled by the hazard unit via `occupied`, not by this block.
- Arithmetic:
  - MULT: signed 32x32 -> 64; hi = product[63:32], lo = product[31:0].
  - MULTU: unsigned 32x32 -> 64; same split.
  - DIV: signed; lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - DIVU: unsigned quotient/remainder.
  - Divide by zero (b==0): the op still occupies DIV_CYCLES, but hi/lo are unchanged at commit.
- No flush input. An MDU op that reaches E is architecturally committed; the E-stage clear zeroes the instruction before it can raise start.

Decomposition:
- Shared package mdu_pkg holds:
  - the op encodings MDU_NONE..MDU_MTLO (3-bit constants);
  - counter width, derived with $clog2 of the maximum of the two parameters, plus 1.
- One combinational sub-module, mdu_calc, is natural:
  - inputs op, a, b;
  - outputs res_hi, res_lo and div_by_zero;
  - it isolates the signed/unsigned arithmetic from the FSM.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 -> busy for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1; occupied=1 in the start cycle.
- MULTU a=0xFFFFFFFF, b=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=7, b=0 with hi=0x11, lo=0x22 preset via MTHI/MTLO -> busy 10 cycles; hi=0x11, lo=0x22 unchanged.
- Start DIVU 100/7, second start MULT in cycle 3, reset pulsed low in cycle 6 -> second start ignored; reset clears everything at once; hi=lo=0, busy=0, no later commit.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings, FSM state type and counter sizing for the multiply/divide unit
package mdu_pkg;
  localparam logic [2:0] MDU_NONE  = 3'd0;
  localparam logic [2:0] MDU_MULT  = 3'd1;
  localparam logic [2:0] MDU_MULTU = 3'd2;
  localparam logic [2:0] MDU_DIV   = 3'd3;
  localparam logic [2:0] MDU_DIVU  = 3'd4;
  localparam logic [2:0] MDU_MTHI  = 3'd5;
  localparam logic [2:0] MDU_MTLO  = 3'd6;

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  // Counter wide enough for the longer of the two latencies, with one spare bit
  function automatic int cnt_width(input int mult_cycles, input int div_cycles);
    return $clog2(mult_cycles > div_cycles ? mult_cycles : div_cycles) + 1;
  endfunction
endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: combinational signed/unsigned 32x32 multiply and divide producing a 64-bit HI/LO result
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_by_zero
);
  logic [63:0] prod_s, prod_u;
  logic [31:0] ma, mb, dvs, dvu, mq, mr, uq, ur, sq, sr;

  // Signed divide works on magnitudes so that 0x80000000 / -1 wraps to 0x80000000 with a zero remainder
  always_comb begin
    div_by_zero = ((op == MDU_DIV) || (op == MDU_DIVU)) && (b == 32'd0);
    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u = {32'd0, a} * {32'd0, b};
    ma = a[31] ? -a : a;
    mb = b[31] ? -b : b;
    dvs = (b == 32'd0) ? 32'd1 : mb;
    dvu = (b == 32'd0) ? 32'd1 : b;
    mq = ma / dvs;
    mr = ma % dvs;
    uq = a / dvu;
    ur = a % dvu;
    sq = (a[31] ^ b[31]) ? -mq : mq;
    sr = a[31] ? -mr : mr;
    {res_hi, res_lo} = (op == MDU_MULT)  ? prod_s :
                       (op == MDU_MULTU) ? prod_u :
                       (op == MDU_DIV)   ? {sr, sq} :
                       (op == MDU_DIVU)  ? {ur, uq} : 64'd0;
  end
endmodule

// File: rtl/mdu_exec.sv
// mdu_exec: E-stage multiply/divide unit holding HI/LO, committing arithmetic results after a fixed latency
module mdu_exec
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        occupied,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int CW = cnt_width(MULT_CYCLES, DIV_CYCLES);

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, phi_q, phi_d, plo_q, plo_d;
  logic        busy_q, busy_d, arith;
  logic [31:0] res_hi, res_lo;
  logic        div_by_zero;

  mdu_calc u_calc (
    .op          (op),
    .a           (a),
    .b           (b),
    .res_hi      (res_hi),
    .res_lo      (res_lo),
    .div_by_zero (div_by_zero)
  );

  // Next state: latch the result at start, count down, commit on the last busy edge; starts while busy are dropped
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    hi_d = hi_q;
    lo_d = lo_q;
    phi_d = phi_q;
    plo_d = plo_q;
    busy_d = busy_q;
    arith = (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    occupied = busy_q | (start & arith);
    if (state_q == ST_IDLE) begin
      if (start && arith) begin
        phi_d = div_by_zero ? hi_q : res_hi;
        plo_d = div_by_zero ? lo_q : res_lo;
        cnt_d = (op == MDU_DIV || op == MDU_DIVU) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        busy_d = 1'b1;
        state_d = ST_BUSY;
      end else if (start && op == MDU_MTHI) begin
        hi_d = a;
      end else if (start && op == MDU_MTLO) begin
        lo_d = a;
      end
    end else begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        hi_d = phi_q;
        lo_d = plo_q;
        busy_d = 1'b0;
        state_d = ST_IDLE;
      end
    end
  end

  // State registers; an active-low reset aborts any operation in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      phi_q <= '0;
      plo_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      phi_q <= phi_d;
      plo_q <= plo_d;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;
  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: tb/tb_mdu_exec.sv
// tb_mdu_exec: randomized and directed checks of mdu_exec against a plain-arithmetic HI/LO model
module tb_mdu_exec;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [2:0] op = 3'd0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic busy, occupied;
  logic [31:0] hi, lo;
  int checks = 0, failures = 0, viol = 0;
  logic [31:0] hi_m = 32'd0, lo_m = 32'd0;

  always #5 clk = ~clk;

  mdu_exec #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .occupied(occupied), .hi(hi), .lo(lo)
  );

  // Protocol monitor: a start presented while the unit is busy violates the hazard-unit contract
  always @(posedge clk) if (reset && busy && start) viol++;

  function automatic int lat(input logic [2:0] o);
    return (o == 3'd1 || o == 3'd2) ? 5 : (o == 3'd3 || o == 3'd4) ? 10 : 0;
  endfunction

  function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint p, q, r;
    longint unsigned pu;
    case (o)
      3'd1: begin p = longint'($signed(x)) * longint'($signed(y)); {hi_m, lo_m} = p; end
      3'd2: begin pu = {32'd0, x} * {32'd0, y}; {hi_m, lo_m} = pu; end
      3'd3: if (y != 0) begin
        q = longint'($signed(x)) / longint'($signed(y));
        r = longint'($signed(x)) % longint'($signed(y));
        lo_m = q[31:0];
        hi_m = r[31:0];
      end
      3'd4: if (y != 0) begin lo_m = x / y; hi_m = x % y; end
      3'd5: hi_m = x;
      3'd6: lo_m = x;
      default: ;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int blen, output bit hold_ok, output bit occ);
    logic [31:0] oh, ol;
    oh = hi_m;
    ol = lo_m;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    #1 occ = occupied;
    @(posedge clk);
    #1 start = 1'b0; op = 3'd0;
    blen = 0;
    hold_ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!busy) break;
      blen++;
      if (hi !== oh || lo !== ol) hold_ok = 1'b0;
    end
    model(o, x, y);
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({busy, occupied, hi, lo} !== 66'd0) begin
      failures++;
      $display("FAIL reset_state: busy=%b occ=%b hi=%h lo=%h want all zero", busy, occupied, hi, lo);
    end
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_directed;
    int blen;
    bit hold, occ;
    logic [31:0] va [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h80000000, 32'h00000011, 32'h00000022};
    logic [31:0] vb [6] = '{32'd5, 32'd2, 32'd2, 32'hFFFFFFFF, 32'd0, 32'd0};
    logic [2:0]  vo [6] = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd5, 3'd6};
    logic [63:0] want [4] = '{64'hFFFFFFFF_FFFFFFF1, 64'h00000001_FFFFFFFE, 64'hFFFFFFFF_FFFFFFFD, 64'h00000000_80000000};
    for (int i = 0; i < 6; i++) begin
      run_op(vo[i], va[i], vb[i], blen, hold, occ);
      checks++;
      if (occ !== (i < 4) || blen !== lat(vo[i]) || !hold) begin
        failures++;
        $display("FAIL directed_timing[%0d]: occ=%b busy_cycles=%0d hold=%b want occ=%b cycles=%0d hold=1", i, occ, blen, hold, i < 4, lat(vo[i]));
      end
      checks++;
      if (i < 4 && {hi, lo} !== want[i]) begin
        failures++;
        $display("FAIL directed_result[%0d]: hi:lo=%h want %h", i, {hi, lo}, want[i]);
      end else if ({hi, lo} !== {hi_m, lo_m}) begin
        failures++;
        $display("FAIL directed_model[%0d]: hi:lo=%h want %h", i, {hi, lo}, {hi_m, lo_m});
      end
    end
  endtask

  task automatic test_div_by_zero;
    int blen;
    bit hold, occ;
    run_op(3'd4, 32'd7, 32'd0, blen, hold, occ);
    checks++;
    if (blen !== 10 || !hold || occ !== 1'b1) begin
      failures++;
      $display("FAIL divz_timing: cycles=%0d hold=%b occ=%b want 10 1 1", blen, hold, occ);
    end
    checks++;
    if (hi !== 32'h11 || lo !== 32'h22) begin
      failures++;
      $display("FAIL divz_result: hi=%h lo=%h want 00000011 00000022", hi, lo);
    end
  endtask

  task automatic test_noop;
    int blen;
    bit hold, occ;
    for (int i = 0; i < 2; i++) begin
      run_op(i == 0 ? 3'd0 : 3'd7, $urandom, $urandom, blen, hold, occ);
      checks++;
      if (blen !== 0 || occ !== 1'b0 || hi !== hi_m || lo !== lo_m) begin
        failures++;
        $display("FAIL noop[%0d]: cycles=%0d occ=%b hi=%h lo=%h want 0 0 %h %h", i, blen, occ, hi, lo, hi_m, lo_m);
      end
    end
  endtask

  task automatic test_random;
    int blen;
    bit hold, occ;
    logic [2:0] o;
    logic [31:0] x, y;
    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom_range(1, 6));
      x = ($urandom_range(0, 5) == 0) ? 32'h80000000 : 32'($urandom);
      case ($urandom_range(0, 4))
        0: y = 32'd0;
        1: y = 32'hFFFFFFFF;
        2: y = 32'($urandom_range(1, 20));
        default: y = 32'($urandom);
      endcase
      run_op(o, x, y, blen, hold, occ);
      checks++;
      if (blen !== lat(o) || !hold || occ !== (lat(o) != 0)) begin
        failures++;
        $display("FAIL rand_timing[%0d] op=%0d: cycles=%0d hold=%b occ=%b want %0d 1 %b", i, o, blen, hold, occ, lat(o), lat(o) != 0);
      end
      checks++;
      if ({hi, lo} !== {hi_m, lo_m}) begin
        failures++;
        $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: hi:lo=%h want %h", i, o, x, y, {hi, lo}, {hi_m, lo_m});
      end
    end
  endtask

  task automatic test_abort;
    int blen;
    bit hold, occ;
    int v0;
    run_op(3'd5, 32'hAAAA5555, 32'd0, blen, hold, occ);
    run_op(3'd6, 32'h5555AAAA, 32'd0, blen, hold, occ);
    v0 = viol;
    @(negedge clk);
    op = 3'd4; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(negedge clk);
    op = 3'd1; a = 32'd3; b = 32'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; op = 3'd0;
    checks++;
    if (viol !== v0 + 1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_ignored_start: violations=%0d busy=%b want %0d 1", viol - v0, busy, 1);
    end
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    hi_m = 32'd0;
    lo_m = 32'd0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++;
      $display("FAIL abort_async_clear: busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
    end
    @(negedge clk) reset = 1'b1;
    repeat (15) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++;
      $display("FAIL abort_no_commit: busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
    end
  endtask

  task automatic test_back_to_back;
    int blen;
    bit hold, occ;
    logic [2:0] o;
    for (int i = 0; i < 4; i++) begin
      o = 3'(i + 1);
      run_op(o, 32'($urandom), 32'($urandom_range(1, 1000)), blen, hold, occ);
      checks++;
      if (blen !== lat(o) || {hi, lo} !== {hi_m, lo_m}) begin
        failures++;
        $display("FAIL b2b[%0d]: cycles=%0d hi:lo=%h want %0d %h", i, blen, {hi, lo}, lat(o), {hi_m, lo_m});
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_div_by_zero;
    test_noop;
    test_random;
    test_back_to_back;
    test_abort;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
